// File: rtl/keypad_pkg.sv
// Shared constants, scan-result encoding and debounce state type for the
// 4x4 keypad scanner.
package keypad_pkg;

   localparam logic [3:0] KEY_IDLE_NUM = 4'hF;
   localparam logic [3:0] KEY_ADD      = 4'hA;
   localparam logic [3:0] KEY_SUB      = 4'hB;
   localparam logic [3:0] KEY_EQ       = 4'hC;
   localparam logic [3:0] KEY_CLR      = 4'hF;

   // Scan result: bit 4 set means no single key was seen
   localparam logic [4:0] KEY_NONE     = 5'b10000;

   typedef enum logic {ST_IDLE, ST_HELD} kp_state_t;

   function automatic logic is_func_key(input logic [3:0] k);
      return (k >= 4'd10);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Accepts a scan result only after DEBOUNCE identical consecutive scans and
// drives the registered tipo/number/valid/strobe outputs.
module key_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scan_done,
   input  logic [4:0] scan_res,
   output logic       tipo,
   output logic [3:0] number,
   output logic       key_valid,
   output logic       key_strobe
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   kp_state_t      state_reg, state_next;
   logic [4:0]     cand_reg, cand_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           tipo_reg, tipo_next;
   logic [3:0]     number_reg, number_next;
   logic           valid_reg, valid_next;
   logic           strobe_reg, strobe_next;
   logic [4:0]     cur_key;
   logic           accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cand_reg   <= KEY_NONE;
         cnt_reg    <= '0;
         tipo_reg   <= 1'b0;
         number_reg <= KEY_IDLE_NUM;
         valid_reg  <= 1'b0;
         strobe_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cand_reg   <= cand_next;
         cnt_reg    <= cnt_next;
         tipo_reg   <= tipo_next;
         number_reg <= number_next;
         valid_reg  <= valid_next;
         strobe_reg <= strobe_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cand_next   = cand_reg;
      cnt_next    = cnt_reg;
      tipo_next   = tipo_reg;
      number_next = number_reg;
      valid_next  = valid_reg;
      strobe_next = 1'b0;
      accept      = 1'b0;
      cur_key     = (state_reg == ST_HELD) ? {1'b0, number_reg} : KEY_NONE;

      if (scan_done) begin
         if (scan_res == cand_reg) begin
            if (cnt_reg < CW'(DEBOUNCE))
               cnt_next = cnt_reg + 1'b1;
         end else begin
            cand_next = scan_res;
            cnt_next  = CW'(1);
         end
         // Re-accepting the key already shown is a no-op, so no repeat strobe
         accept = (cnt_next == CW'(DEBOUNCE)) && (cand_next != cur_key);

         if (accept) begin
            case (state_reg)
               ST_IDLE: begin
                  if (!cand_next[4]) begin
                     state_next  = ST_HELD;
                     tipo_next   = is_func_key(cand_next[3:0]);
                     number_next = cand_next[3:0];
                     valid_next  = 1'b1;
                     strobe_next = 1'b1;
                  end
               end
               ST_HELD: begin
                  if (cand_next[4]) begin
                     state_next  = ST_IDLE;
                     tipo_next   = 1'b0;
                     number_next = KEY_IDLE_NUM;
                     valid_next  = 1'b0;
                  end else begin
                     tipo_next   = is_func_key(cand_next[3:0]);
                     number_next = cand_next[3:0];
                     strobe_next = 1'b1;
                  end
               end
               default: state_next = ST_IDLE;
            endcase
         end
      end
   end

   assign tipo       = tipo_reg;
   assign number     = number_reg;
   assign key_valid  = valid_reg;
   assign key_strobe = strobe_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronizes rows, walks the columns,
// reduces each full scan to one key code (or NONE) and debounces it.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       tipo,
   output logic [3:0] number,
   output logic       key_valid,
   output logic       key_strobe
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [3:0]    sync1_reg, sync2_reg;
   logic [DW-1:0] dwell_reg;
   logic [1:0]    col_reg;
   logic [1:0]    acc_cnt_reg;
   logic [3:0]    acc_code_reg;

   logic          last_dwell;
   logic [3:0]    lows;
   logic [1:0]    hits;
   logic [1:0]    row_idx;
   logic [2:0]    sum;
   logic [1:0]    total;
   logic [3:0]    code_next;
   logic          scan_done;
   logic [4:0]    scan_res;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg    <= 4'b1111;
         sync2_reg    <= 4'b1111;
         dwell_reg    <= '0;
         col_reg      <= 2'd0;
         acc_cnt_reg  <= 2'd0;
         acc_code_reg <= 4'd0;
      end else begin
         sync1_reg <= rows;
         sync2_reg <= sync1_reg;
         if (last_dwell) begin
            dwell_reg <= '0;
            col_reg   <= col_reg + 2'd1;
            if (col_reg == 2'd3) begin
               acc_cnt_reg  <= 2'd0;
               acc_code_reg <= 4'd0;
            end else begin
               acc_cnt_reg  <= total;
               acc_code_reg <= code_next;
            end
         end else begin
            dwell_reg <= dwell_reg + 1'b1;
         end
      end
   end

   // hits saturates at 2: anything beyond one key per scan is rejected anyway
   always_comb begin
      lows    = ~sync2_reg;
      hits    = 2'd0;
      row_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (lows[i]) begin
            row_idx = 2'(i);
            if (hits != 2'd2)
               hits = hits + 2'd1;
         end
      end
      sum       = {1'b0, acc_cnt_reg} + {1'b0, hits};
      total     = (sum > 3'd2) ? 2'd2 : sum[1:0];
      code_next = (hits == 2'd1) ? {col_reg, row_idx} : acc_code_reg;
      last_dwell = (dwell_reg == DW'(SCAN_DIV - 1));
      scan_done  = last_dwell && (col_reg == 2'd3);
      scan_res   = (total == 2'd1) ? {1'b0, code_next} : KEY_NONE;
   end

   assign cols = ~(4'b0001 << col_reg);

   key_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .scan_done  (scan_done),
      .scan_res   (scan_res),
      .tipo       (tipo),
      .number     (number),
      .key_valid  (key_valid),
      .key_strobe (key_strobe)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives rows from cols and a
// set of pressed keys; expectations come from the key set itself.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int LAT      = (DEBOUNCE + 1) * 4 * SCAN_DIV + 3;
   localparam int NONE_K   = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic        tipo;
   logic [3:0]  number;
   logic        key_valid;
   logic        key_strobe;

   logic [15:0] pressed = 16'h0;
   int          vectors = 0;
   int          miscompares = 0;
   int          strobe_cnt = 0;
   logic [3:0]  last_strobe_num = 4'h0;

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rows       (rows),
      .cols       (cols),
      .tipo       (tipo),
      .number     (number),
      .key_valid  (key_valid),
      .key_strobe (key_strobe)
   );

   always #5 clk = ~clk;

   // Key 4*c+r pulls row r low while column c is driven low
   always_comb begin
      rows = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[4*c+r] && !cols[c])
               rows[r] = 1'b0;
   end

   always @(posedge clk) begin
      #1;
      if (key_strobe === 1'b1) begin
         strobe_cnt++;
         last_strobe_num = number;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   // Reference: the key the outputs should settle on for a given key set
   function automatic int eff_key(input logic [15:0] m);
      if ($countones(m) != 1) return NONE_K;
      for (int k = 0; k < 16; k++)
         if (m[k]) return k;
      return NONE_K;
   endfunction

   task automatic wait_for_valid(input logic want, output int waited);
      waited = 0;
      while (key_valid !== want && waited < LAT + 20) begin
         @(negedge clk);
         waited++;
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_cols;
      int s0;
      pressed = 16'h0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (cols !== 4'b1110) begin miscompares++; $display("FAIL reset_cols got %b want 1110", cols); end
      vectors++; if (tipo !== 1'b0) begin miscompares++; $display("FAIL reset_tipo got %b want 0", tipo); end
      vectors++; if (number !== 4'hF) begin miscompares++; $display("FAIL reset_number got %h want F", number); end
      vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", key_valid); end
      vectors++; if (key_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got %b want 0", key_strobe); end
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         exp_cols = ~(4'b0001 << ((i / SCAN_DIV) % 4));
         vectors++;
         if (cols !== exp_cols) begin
            miscompares++;
            $display("FAIL col_walk cycle %0d got %b want %b", i, cols, exp_cols);
         end
         @(negedge clk);
      end
      s0 = strobe_cnt;
      repeat (200) @(negedge clk);
      vectors++; if (strobe_cnt !== s0) begin miscompares++; $display("FAIL idle_strobe got %0d strobes want 0", strobe_cnt - s0); end
      vectors++; if (key_valid !== 1'b0 || number !== 4'hF || tipo !== 1'b0) begin
         miscompares++; $display("FAIL idle_outputs got valid=%b number=%h tipo=%b want 0/F/0", key_valid, number, tipo);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      int s0, w;
      s0 = strobe_cnt;
      pressed = 16'h1 << 7;
      wait_for_valid(1'b1, w);
      vectors++; if (w > LAT) begin miscompares++; $display("FAIL press_latency got %0d want <= %0d", w, LAT); end
      vectors++; if (number !== 4'h7 || tipo !== 1'b0) begin miscompares++; $display("FAIL key7 got number=%h tipo=%b want 7/0", number, tipo); end
      vectors++; if (strobe_cnt !== s0 + 1 || last_strobe_num !== 4'h7) begin
         miscompares++; $display("FAIL key7_strobe got %0d strobes num=%h want 1 num=7", strobe_cnt - s0, last_strobe_num);
      end
      repeat (300) @(negedge clk);
      vectors++; if (strobe_cnt !== s0 + 1 || key_valid !== 1'b1) begin
         miscompares++; $display("FAIL key7_hold got %0d strobes valid=%b want 1 strobe valid=1", strobe_cnt - s0, key_valid);
      end
      pressed = 16'h0;
      wait_for_valid(1'b0, w);
      vectors++; if (w > LAT) begin miscompares++; $display("FAIL release_latency got %0d want <= %0d", w, LAT); end
      vectors++; if (number !== 4'hF || tipo !== 1'b0 || strobe_cnt !== s0 + 1) begin
         miscompares++; $display("FAIL key7_release got number=%h tipo=%b strobes=%0d want F/0/1", number, tipo, strobe_cnt - s0);
      end
      $display("test_single done");
   endtask

   task automatic test_rollover();
      int s1, w;
      logic dropped;
      pressed = 16'h1 << 10;
      wait_for_valid(1'b1, w);
      vectors++; if (w > LAT || number !== 4'hA || tipo !== 1'b1) begin
         miscompares++; $display("FAIL key_A got lat=%0d number=%h tipo=%b want <=%0d/A/1", w, number, tipo, LAT);
      end
      s1 = strobe_cnt;
      dropped = 1'b0;
      pressed = 16'h1 << 12;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (key_valid !== 1'b1) dropped = 1'b1;
      end
      vectors++; if (dropped !== 1'b0) begin miscompares++; $display("FAIL roll_valid got drop=%b want 0", dropped); end
      vectors++; if (number !== 4'hC || tipo !== 1'b1 || strobe_cnt !== s1 + 1) begin
         miscompares++; $display("FAIL roll_C got number=%h tipo=%b strobes=%0d want C/1/1", number, tipo, strobe_cnt - s1);
      end
      pressed = 16'h0;
      wait_for_valid(1'b0, w);
      vectors++; if (w > LAT) begin miscompares++; $display("FAIL roll_release got %0d want <= %0d", w, LAT); end
      $display("test_rollover done");
   endtask

   task automatic test_bounce();
      int s0, w;
      s0 = strobe_cnt;
      for (int i = 0; i < 12; i++) begin
         pressed = pressed ^ (16'h1 << 1);
         repeat (5) @(negedge clk);
      end
      vectors++; if (strobe_cnt !== s0 || key_valid !== 1'b0) begin
         miscompares++; $display("FAIL bounce_reject got strobes=%0d valid=%b want 0/0", strobe_cnt - s0, key_valid);
      end
      pressed = 16'h1 << 1;
      wait_for_valid(1'b1, w);
      vectors++; if (w > LAT || number !== 4'h1 || strobe_cnt !== s0 + 1) begin
         miscompares++; $display("FAIL bounce_accept got lat=%0d number=%h strobes=%0d want <=%0d/1/1", w, number, strobe_cnt - s0, LAT);
      end
      pressed = 16'h0;
      wait_for_valid(1'b0, w);
      $display("test_bounce done");
   endtask

   task automatic test_ghost();
      int s0, w;
      s0 = strobe_cnt;
      pressed = (16'h1 << 5) | (16'h1 << 9);
      repeat (LAT + 40) @(negedge clk);
      vectors++; if (key_valid !== 1'b0 || number !== 4'hF || strobe_cnt !== s0) begin
         miscompares++; $display("FAIL ghost_reject got valid=%b number=%h strobes=%0d want 0/F/0", key_valid, number, strobe_cnt - s0);
      end
      pressed = 16'h1 << 5;
      wait_for_valid(1'b1, w);
      vectors++; if (w > LAT || number !== 4'h5 || strobe_cnt !== s0 + 1) begin
         miscompares++; $display("FAIL ghost_release got lat=%0d number=%h strobes=%0d want <=%0d/5/1", w, number, strobe_cnt - s0, LAT);
      end
      pressed = 16'h0;
      wait_for_valid(1'b0, w);
      $display("test_ghost done");
   endtask

   task automatic test_reset_mid();
      int s0, w;
      pressed = 16'h1 << 3;
      wait_for_valid(1'b1, w);
      vectors++; if (number !== 4'h3) begin miscompares++; $display("FAIL key3 got %h want 3", number); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      vectors++; if (key_valid !== 1'b0 || number !== 4'hF || tipo !== 1'b0 || key_strobe !== 1'b0 || cols !== 4'b1110) begin
         miscompares++;
         $display("FAIL async_reset got valid=%b number=%h tipo=%b strobe=%b cols=%b want 0/F/0/0/1110",
                  key_valid, number, tipo, key_strobe, cols);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      s0 = strobe_cnt;
      wait_for_valid(1'b1, w);
      vectors++; if (w > LAT || number !== 4'h3 || strobe_cnt !== s0 + 1) begin
         miscompares++; $display("FAIL reaccept got lat=%0d number=%h strobes=%0d want <=%0d/3/1", w, number, strobe_cnt - s0, LAT);
      end
      pressed = 16'h0;
      wait_for_valid(1'b0, w);
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      int old_eff, new_eff, s0, exp_strobes, k1, k2, n;
      logic [15:0] m;
      logic [3:0]  exp_num;
      old_eff = NONE_K;
      for (int it = 0; it < 24; it++) begin
         n  = $urandom_range(0, 2);
         k1 = $urandom_range(0, 15);
         k2 = (k1 + 1 + $urandom_range(0, 14)) % 16;
         m  = 16'h0;
         if (n >= 1) m[k1] = 1'b1;
         if (n == 2) m[k2] = 1'b1;
         new_eff = eff_key(m);
         exp_strobes = (new_eff != old_eff && new_eff != NONE_K) ? 1 : 0;
         exp_num = (new_eff == NONE_K) ? 4'hF : 4'(new_eff);
         s0 = strobe_cnt;
         pressed = m;
         repeat (LAT) @(negedge clk);
         vectors++;
         if (key_valid !== (new_eff != NONE_K) || number !== exp_num ||
             tipo !== (new_eff != NONE_K && new_eff >= 10)) begin
            miscompares++;
            $display("FAIL rand_%0d mask=%h got valid=%b number=%h tipo=%b want number=%h",
                     it, m, key_valid, number, tipo, exp_num);
         end
         repeat ($urandom_range(0, 40)) @(negedge clk);
         vectors++;
         if (strobe_cnt - s0 !== exp_strobes) begin
            miscompares++;
            $display("FAIL rand_strobe_%0d mask=%h got %0d strobes want %0d", it, m, strobe_cnt - s0, exp_strobes);
         end
         $display("rand %0d mask=%h expect key=%0d strobes=%0d", it, m, new_eff, exp_strobes);
         old_eff = new_eff;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rollover();
      test_bounce();
      test_ghost();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
